// File: rtl/fxp_pkg.sv
// Shared fixed-point constants and width helpers for the multiply/resize blocks.
package fxp_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int ROUND_CONV    = 2;

  // Full-precision width of a signed (wi1.wf1) x (wi2.wf2) product.
  function automatic int prod_width(input int wi1, input int wf1,
                                    input int wi2, input int wf2);
    return wi1 + wf1 + wi2 + wf2;
  endfunction

endpackage

// File: rtl/fxp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined fixed-point multiplier.
interface fxp_mult_pipe_if #(
  parameter int W1 = 7,
  parameter int W2 = 7,
  parameter int WO = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W1-1:0] in1;
  logic signed [W2-1:0] in2;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WO-1:0] out;
  logic                 ovf;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/fxp_resize.sv
// Combinational resize of a signed (WII.WFI) value to (WIO.WFO): round, then
// wrap or saturate on integer overflow. Shared with the fixed-point add/MAC blocks.
module fxp_resize
  import fxp_pkg::*;
#(
  parameter int WII   = 6,
  parameter int WFI   = 8,
  parameter int WIO   = 4,
  parameter int WFO   = 4,
  parameter int ROUND = ROUND_HALF_UP,
  parameter int SAT   = 1
) (
  input  logic signed [WII+WFI-1:0] din,
  output logic signed [WIO+WFO-1:0] dout,
  output logic                      ovf
);

  // One extra integer bit keeps a rounding carry from wrapping.
  localparam int RW = WII + 1 + WFO;
  localparam int OW = WIO + WFO;

  logic signed [RW-1:0] r;

  if (WFO >= WFI) begin : g_widen
    assign r = RW'(din) <<< (WFO - WFI);
  end else begin : g_round
    localparam int D  = WFI - WFO;
    localparam int EW = WII + 1 + WFI;
    localparam logic signed [EW-1:0] HALF = EW'(1) << (D - 1);
    localparam logic [D-1:0]         TIE  = D'(1) << (D - 1);

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] sum;
    logic signed [RW-1:0] r_t;
    logic signed [RW-1:0] r_h;

    assign ext = EW'(din);
    assign sum = ext + HALF;
    assign r_t = RW'(ext >>> D);
    assign r_h = RW'(sum >>> D);

    // Pick rounding mode; on an exact tie, clearing the half-up LSB lands on the even neighbour.
    always_comb begin
      r = r_t;
      if (ROUND == ROUND_HALF_UP) r = r_h;
      else if (ROUND == ROUND_CONV) r = (din[D-1:0] == TIE) ? {r_h[RW-1:1], 1'b0} : r_h;
    end
  end

  if (WIO >= WII + 1) begin : g_fits
    assign dout = OW'(r);
    assign ovf  = 1'b0;
  end else begin : g_fit
    localparam logic [OW-1:0] MIN = OW'(1) << (OW - 1);

    logic [RW-OW:0] hi;

    assign hi  = r[RW-1:OW-1];
    assign ovf = !((&hi) || !(|hi));

    // Drop the high bits, or clamp to the format limits when saturating.
    always_comb begin
      dout = r[OW-1:0];
      if (ovf && SAT != 0) dout = r[RW-1] ? MIN : ~MIN;
    end
  end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with global-stall valid/ready flow.
// Stage order: input reg (STAGES>=2), product reg (>=3), rounded reg (==4), output reg.
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int WI1    = 4,
  parameter int WF1    = 3,
  parameter int WI2    = 2,
  parameter int WF2    = 5,
  parameter int WIO    = 4,
  parameter int WFO    = 4,
  parameter int STAGES = 3,
  parameter int ROUND  = ROUND_HALF_UP,
  parameter int SAT    = 1
) (
  input logic            CLK,
  input logic            RST,
  fxp_mult_pipe_if.slave bus
);

  localparam int W1  = WI1 + WF1;
  localparam int W2  = WI2 + WF2;
  localparam int WIP = WI1 + WI2;
  localparam int WFP = WF1 + WF2;
  localparam int WP  = prod_width(WI1, WF1, WI2, WF2);
  localparam int WO  = WIO + WFO;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("fxp_mult_pipe: STAGES must be in 1..4");
  end
  if (ROUND < ROUND_TRUNC || ROUND > ROUND_CONV) begin : g_bad_round
    $error("fxp_mult_pipe: ROUND must be 0, 1 or 2");
  end

  logic                 adv;
  logic                 mv;
  logic signed [W1-1:0] ma;
  logic signed [W2-1:0] mb;
  logic signed [WP-1:0] prod;
  logic                 pv;
  logic signed [WP-1:0] pd;
  logic                 fv;
  logic signed [WO-1:0] fres;
  logic                 fovf;

  // Whole pipe moves together; an empty output slot lets it fill even when downstream stalls.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  if (STAGES >= 2) begin : g_in_reg
    // Input register: capture the operand pair (or a bubble) on every advance.
    always_ff @(posedge CLK) begin
      if (!RST) begin
        mv <= 1'b0;
      end else if (adv) begin
        mv <= bus.in_valid;
        ma <= bus.in1;
        mb <= bus.in2;
      end
    end
  end else begin : g_in_comb
    assign mv = bus.in_valid;
    assign ma = bus.in1;
    assign mb = bus.in2;
  end

  assign prod = WP'(ma) * WP'(mb);

  if (STAGES >= 3) begin : g_prod_reg
    // Product register: full-precision product.
    always_ff @(posedge CLK) begin
      if (!RST) begin
        pv <= 1'b0;
      end else if (adv) begin
        pv <= mv;
        pd <= prod;
      end
    end
  end else begin : g_prod_comb
    assign pv = mv;
    assign pd = prod;
  end

  if (STAGES == 4) begin : g_rnd_reg
    localparam int WR = WIP + 1 + WFO;

    logic signed [WR-1:0] rnd;
    logic signed [WR-1:0] r3;
    logic                 rnd_ovf;
    logic                 r3_ovf;
    logic                 sat_ovf;
    logic                 v3;

    // Round only: the target keeps one spare integer bit, so this half never overflows.
    fxp_resize #(
      .WII(WIP), .WFI(WFP), .WIO(WIP + 1), .WFO(WFO), .ROUND(ROUND), .SAT(0)
    ) u_round (
      .din(pd), .dout(rnd), .ovf(rnd_ovf)
    );

    // Rounded, pre-saturation register.
    always_ff @(posedge CLK) begin
      if (!RST) begin
        v3 <= 1'b0;
      end else if (adv) begin
        v3     <= pv;
        r3     <= rnd;
        r3_ovf <= rnd_ovf;
      end
    end

    fxp_resize #(
      .WII(WIP + 1), .WFI(WFO), .WIO(WIO), .WFO(WFO), .ROUND(ROUND), .SAT(SAT)
    ) u_sat (
      .din(r3), .dout(fres), .ovf(sat_ovf)
    );

    assign fv   = v3;
    assign fovf = r3_ovf | sat_ovf;
  end else begin : g_rnd_comb
    fxp_resize #(
      .WII(WIP), .WFI(WFP), .WIO(WIO), .WFO(WFO), .ROUND(ROUND), .SAT(SAT)
    ) u_resize (
      .din(pd), .dout(fres), .ovf(fovf)
    );

    assign fv = pv;
  end

  // Output register; bubbles present as zero data with ovf clear.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.ovf       <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= fv;
      bus.out       <= fv ? fres : '0;
      bus.ovf       <= fv & fovf;
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe: seven instances covering the rounding,
// overflow and latency variants, all driven with the same stimulus.
module tb_fxp_mult_pipe;
  import fxp_pkg::*;

  localparam int NDUT = 7;
  localparam int CFG_ST  [NDUT] = '{3, 3, 3, 3, 1, 2, 4};
  localparam int CFG_RD  [NDUT] = '{1, 1, 2, 0, 1, 1, 1};
  localparam int CFG_SAT [NDUT] = '{1, 0, 1, 1, 1, 1, 1};
  // Which expected-value column applies: 0=half-up/sat, 1=half-up/wrap, 2=convergent, 3=truncate
  localparam int CFG_COL [NDUT] = '{0, 1, 2, 3, 0, 0, 0};
  localparam int NVEC = 12;

  typedef struct packed {
    logic [6:0]      in1;
    logic [6:0]      in2;
    logic [3:0][7:0] o;
    logic [3:0]      v;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic       in_valid;
  logic [6:0] in1;
  logic [6:0] in2;
  logic       out_ready;

  logic [NDUT-1:0]      mon_ov;
  logic [NDUT-1:0]      mon_ir;
  logic [NDUT-1:0]      mon_ovf;
  logic [NDUT-1:0][7:0] mon_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int cap_cnt [NDUT] = '{default: 0};
  int cap_cyc [NDUT] = '{default: 0};
  int acc_cyc [NDUT] = '{default: 0};
  logic [7:0] cap_out [NDUT] = '{default: 8'h00};
  logic       cap_ovf [NDUT] = '{default: 1'b0};
  logic [8:0] q0 [$];
  vec_t vecs [NVEC];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fxp_mult_pipe_if #(.W1(7), .W2(7), .WO(8)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in1       = in1;
    assign bus.in2       = in2;
    assign bus.out_ready = out_ready;
    assign mon_ov[g]     = bus.out_valid;
    assign mon_ir[g]     = bus.in_ready;
    assign mon_ovf[g]    = bus.ovf;
    assign mon_out[g]    = bus.out;

    fxp_mult_pipe #(
      .STAGES(CFG_ST[g]), .ROUND(CFG_RD[g]), .SAT(CFG_SAT[g])
    ) u_dut (
      .CLK(CLK), .RST(RST), .bus(bus)
    );
  end

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record acceptances and consumed results, half a cycle away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NDUT; i++) begin
        if (in_valid && mon_ir[i]) acc_cyc[i] = cyc;
        if (mon_ov[i] && out_ready) begin
          cap_cnt[i] = cap_cnt[i] + 1;
          cap_out[i] = mon_out[i];
          cap_ovf[i] = mon_ovf[i];
          cap_cyc[i] = cyc;
          if (i == 0) q0.push_back({mon_ovf[i], mon_out[i]});
        end
      end
    end
  end

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [6:0] a, input logic [6:0] b,
                         input logic [7:0] oa, input logic va, input logic [7:0] ob, input logic vb,
                         input logic [7:0] oc, input logic vc, input logic [7:0] od, input logic vd);
    vecs[k].in1  = a;
    vecs[k].in2  = b;
    vecs[k].o[0] = oa;
    vecs[k].v[0] = va;
    vecs[k].o[1] = ob;
    vecs[k].v[1] = vb;
    vecs[k].o[2] = oc;
    vecs[k].v[2] = vc;
    vecs[k].o[3] = od;
    vecs[k].v[3] = vd;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check({tag, "_out_valid"}, i, 32'(mon_ov[i]), 32'd0);
      check({tag, "_out"}, i, 32'(mon_out[i]), 32'd0);
      check({tag, "_ovf"}, i, 32'(mon_ovf[i]), 32'd0);
      check({tag, "_in_ready"}, i, 32'(mon_ir[i]), 32'd1);
    end
  endtask

  initial begin
    int sidx [6] = '{0, 2, 4, 5, 7, 9};
    int base [NDUT];
    int sent;
    int qbase;
    logic prev_stall;
    logic [7:0] prev_out;

    //       in1    in2    half-up/sat   half-up/wrap  convergent    truncate
    set_vec(0,  7'h0C, 7'h10, 8'h0C, 1'b0, 8'h0C, 1'b0, 8'h0C, 1'b0, 8'h0C, 1'b0); //  1.5 * 0.5
    set_vec(1,  7'h40, 7'h40, 8'h7F, 1'b1, 8'h00, 1'b1, 8'h7F, 1'b1, 8'h7F, 1'b1); // -8 * -2 = 16
    set_vec(2,  7'h01, 7'h08, 8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0); // +0.5 LSB tie
    set_vec(3,  7'h7F, 7'h08, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0); // -0.5 LSB tie
    set_vec(4,  7'h03, 7'h08, 8'h02, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0, 8'h01, 1'b0); //  1.5 LSB tie
    set_vec(5,  7'h05, 7'h08, 8'h03, 1'b0, 8'h03, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0); //  2.5 LSB tie
    set_vec(6,  7'h3F, 7'h40, 8'h80, 1'b1, 8'h04, 1'b1, 8'h80, 1'b1, 8'h80, 1'b1); // 7.875 * -2
    set_vec(7,  7'h40, 7'h10, 8'hC0, 1'b0, 8'hC0, 1'b0, 8'hC0, 1'b0, 8'hC0, 1'b0); // -8 * 0.5
    set_vec(8,  7'h3C, 7'h22, 8'h7F, 1'b1, 8'h80, 1'b1, 8'h7F, 1'b1, 8'h7F, 1'b0); // 127.5 LSB: carry overflows
    set_vec(9,  7'h40, 7'h20, 8'h80, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0); // exact minimum
    set_vec(10, 7'h44, 7'h22, 8'h81, 1'b0, 8'h81, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0); // -127.5 LSB tie
    set_vec(11, 7'h00, 7'h55, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0); // zero

    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;
    RST       = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_reset_state("init");

    // Single operand pairs: value, overflow and latency on every variant.
    for (int k = 0; k < NVEC; k++) begin
      for (int i = 0; i < NDUT; i++) base[i] = cap_cnt[i];
      @(posedge CLK); #1;
      in_valid = 1'b1;
      in1      = vecs[k].in1;
      in2      = vecs[k].in2;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (6) @(negedge CLK);
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("v%0d_count", k), i, 32'(cap_cnt[i] - base[i]), 32'd1);
        check($sformatf("v%0d_out", k), i, 32'(cap_out[i]), 32'(vecs[k].o[CFG_COL[i]]));
        check($sformatf("v%0d_ovf", k), i, 32'(cap_ovf[i]), 32'(vecs[k].v[CFG_COL[i]]));
        check($sformatf("v%0d_latency", k), i, 32'(cap_cyc[i] - acc_cyc[i]), 32'(CFG_ST[i]));
      end
    end

    // Back-to-back stream with a 5-cycle downstream stall (observed on the default instance).
    qbase      = q0.size();
    sent       = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      out_ready = (k < 4) || (k >= 9);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in1 = vecs[sidx[sent]].in1;
        in2 = vecs[sidx[sent]].in2;
      end
      @(negedge CLK);
      check("stream_in_ready", 0, 32'(mon_ir[0]), 32'(!(mon_ov[0] && !out_ready)));
      if (prev_stall) check("stream_hold", 0, 32'(mon_out[0]), 32'(prev_out));
      if (in_valid && mon_ir[0]) sent++;
      prev_stall = mon_ov[0] && !out_ready;
      prev_out   = mon_out[0];
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge CLK);
    check("stream_sent", 0, 32'(sent), 32'd6);
    check("stream_count", 0, 32'(q0.size() - qbase), 32'd6);
    for (int j = 0; j < 6; j++) begin
      if (qbase + j < q0.size())
        check($sformatf("stream_res%0d", j), 0, 32'(q0[qbase + j]),
              32'({vecs[sidx[j]].v[0], vecs[sidx[j]].o[0]}));
      else
        check($sformatf("stream_res%0d", j), 0, 32'hDEAD, 32'({vecs[sidx[j]].v[0], vecs[sidx[j]].o[0]}));
    end

    // Reset with three results in flight.
    repeat (10) @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1;
      in1      = vecs[4 + k].in1;
      in2      = vecs[4 + k].in2;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    RST      = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_state("midrst");
    for (int i = 0; i < NDUT; i++) base[i] = cap_cnt[i];
    repeat (8) @(negedge CLK);
    for (int i = 0; i < NDUT; i++)
      check("midrst_no_stale", i, 32'(cap_cnt[i] - base[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
